strided_buffer_reader: RTL and testbench

//  Read-side sequencer for the N_BUF_X-bank strided activation buffer. The write side places pixel (x,y,cw) in

---
 rtl/strided_buf_pkg.sv | 17 +
 rtl/sbuf_skid_fifo.sv | 54 +++++
 rtl/strided_buffer_reader.sv | 215 +++++++++++++++++++++
 tb/tb_strided_buffer_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/strided_buf_pkg.sv
// rtl/strided_buf_pkg.sv - shared definitions for the strided activation buffer reader/writer
package strided_buf_pkg;

  localparam int SHAPE_C_LSB   = 0;
  localparam int SHAPE_H_LSB   = 16;
  localparam int SHAPE_W_LSB   = 32;
  localparam int SHAPE_FIELD_W = 16;
  localparam int CW_SHIFT      = 6;
  localparam int CW_W          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sbuf_skid_fifo.sv
// rtl/sbuf_skid_fifo.sv - shift-down sync FIFO whose head entry is a register driving the output
module sbuf_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             pop_eff;
  logic [PTR_W-1:0] wr_idx;

  assign pop_eff = pop_i && (count_q != '0);
  // Entries move down on pop, so a push lands one slot lower when it coincides with a pop.
  assign wr_idx  = PTR_W'(count_q - CNT_W'(pop_eff));

  always_ff @(posedge clk) begin
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_q[i] <= mem_q[i+1];
      end
    end
    if (push_i) begin
      mem_q[wr_idx] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/strided_buffer_reader.sv
// rtl/strided_buffer_reader.sv - read sequencer for the banked strided activation buffer
module strided_buffer_reader
  import strided_buf_pkg::*;
#(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 48,
  parameter int B_COORD    = 8,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr_i,
  input  logic [B_SHAPE-1:0]               shape_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  input  logic [B_COORD-1:0]               wr_x_i,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]    rdaddr_o,
  input  logic [DATA_WIDTH*N_BUF_X-1:0]    rd_do_i,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [DATA_WIDTH*N_BUF_X-1:0]    m_data_o,
  output logic [N_BUF_X-1:0]               m_mask_o,
  output logic [3*B_COORD-1:0]             m_coord_o,
  output logic                             m_last_o
);

  localparam int FW     = SHAPE_FIELD_W;
  localparam int SB_W   = N_BUF_X + 3*B_COORD + 1;
  localparam int E_W    = DATA_WIDTH*N_BUF_X + SB_W;
  localparam int FC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [FW:0] N_EXT = (FW+1)'(N_BUF_X);

  state_e               state_q;
  logic                 busy_q, done_q;
  logic [B_BUF_ADDR-1:0] rdaddr_q;
  logic [CW_W-1:0]      cw_n_q, cw_q, cw_d;
  logic [FW-1:0]        h_q, w_q, y_q, y_d, g_q, g_d;
  logic [FW:0]          bound_q, bound_d;

  logic [FW-1:0]        c_in, h_in, w_in;
  logic [CW_W-1:0]      cw_in;
  logic                 zero_shape;

  logic [RD_LAT-1:0]    vld_sr_q;
  logic [SB_W-1:0]      sb_sr_q [RD_LAT];
  logic [SB_W-1:0]      sb_new;
  logic [N_BUF_X-1:0]   mask_new;
  logic [CNT_W-1:0]     inflight;

  logic [E_W-1:0]       fifo_head;
  logic [FC_W-1:0]      fifo_count;
  logic                 fifo_full, fifo_empty;

  logic                 last_grp, last_read, credit_ok, col_ok, issue, pop;
  logic [FW:0]          col_need;
  logic                 unused_sig;

  assign c_in       = shape_i[SHAPE_C_LSB +: FW];
  assign h_in       = shape_i[SHAPE_H_LSB +: FW];
  assign w_in       = shape_i[SHAPE_W_LSB +: FW];
  assign cw_in      = c_in[CW_SHIFT +: CW_W];
  assign zero_shape = (cw_in == '0) || (h_in == '0) || (w_in == '0);
  assign unused_sig = ^{c_in, fifo_full};

  // bound_q is the exclusive column end of group g; the writer must have covered min(bound, W).
  assign last_grp  = bound_q >= {1'b0, w_q};
  assign col_need  = last_grp ? {1'b0, w_q} : bound_q;
  assign col_ok    = {{(FW+1-B_COORD){1'b0}}, wr_x_i} >= col_need;
  assign last_read = (cw_q == cw_n_q - CW_W'(1)) && (y_q == h_q - FW'(1)) && last_grp;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_sr_q[i]);
    end
  end

  assign credit_ok = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);
  assign issue     = (state_q == RUN) && credit_ok && col_ok;
  assign pop       = m_valid_o && m_ready_i;

  always_comb begin
    cw_d    = cw_q;
    y_d     = y_q;
    g_d     = g_q;
    bound_d = bound_q;
    if (cw_q == cw_n_q - CW_W'(1)) begin
      cw_d = '0;
      if (y_q == h_q - FW'(1)) begin
        y_d     = '0;
        g_d     = g_q + FW'(1);
        bound_d = bound_q + N_EXT;
      end else begin
        y_d = y_q + FW'(1);
      end
    end else begin
      cw_d = cw_q + CW_W'(1);
    end
  end

  always_comb begin
    mask_new = '0;
    for (int i = 0; i < N_BUF_X; i++) begin
      mask_new[i] = (bound_q - N_EXT + (FW+1)'(i)) < {1'b0, w_q};
    end
  end

  assign sb_new = {mask_new, B_COORD'(cw_q), B_COORD'(y_q), B_COORD'(g_q), last_read};

  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdaddr_q <= '0;
      cw_n_q   <= '0;
      h_q      <= '0;
      w_q      <= '0;
      cw_q     <= '0;
      y_q      <= '0;
      g_q      <= '0;
      bound_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cw_n_q   <= cw_in;
            h_q      <= h_in;
            w_q      <= w_in;
            cw_q     <= '0;
            y_q      <= '0;
            g_q      <= '0;
            bound_q  <= N_EXT;
            rdaddr_q <= '0;
            if (zero_shape) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rdaddr_q <= rdaddr_q + B_BUF_ADDR'(1);
            cw_q     <= cw_d;
            y_q      <= y_d;
            g_q      <= g_d;
            bound_q  <= bound_d;
            if (last_read) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last_o) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat sideband rides alongside the BRAM latency so it lines up with rd_do.
  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    sb_sr_q[0] <= sb_new;
    for (int i = 1; i < RD_LAT; i++) begin
      sb_sr_q[i] <= sb_sr_q[i-1];
    end
  end

  sbuf_skid_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FC_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr_i),
    .push_i  (vld_sr_q[RD_LAT-1]),
    .din_i   ({rd_do_i, sb_sr_q[RD_LAT-1]}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {m_data_o, m_mask_o, m_coord_o, m_last_o} = fifo_head;
  assign m_valid_o = !fifo_empty;
  assign rdaddr_o  = {N_BUF_X{rdaddr_q}};
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_strided_buffer_reader.sv
// tb/tb_strided_buffer_reader.sv - self-checking bench for strided_buffer_reader
module tb_strided_buffer_reader;

  localparam int N  = 5;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int BC = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clr = 1'b0;
  logic              start = 1'b0;
  logic              m_ready = 1'b0;
  logic [47:0]       shape = '0;
  logic [BC-1:0]     wr_x = '0;
  logic [AW*N-1:0]   rdaddr;
  logic [DW*N-1:0]   rd_do = '0;
  logic              busy, done, m_valid, m_last;
  logic [DW*N-1:0]   m_data;
  logic [N-1:0]      m_mask;
  logic [3*BC-1:0]   m_coord;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [DW*N-1:0] data;
    logic [N-1:0]    mask;
    logic [3*BC-1:0] coord;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  logic [DW-1:0] bank_mem [N][512];

  strided_buffer_reader dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (clr),
    .shape_i   (shape),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .wr_x_i    (wr_x),
    .rdaddr_o  (rdaddr),
    .rd_do_i   (rd_do),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_mask_o  (m_mask),
    .m_coord_o (m_coord),
    .m_last_o  (m_last)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM banks sharing the replicated address.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      rd_do[i*DW +: DW] <= bank_mem[i][rdaddr[i*AW +: AW]];
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats straight from the writer's pixel layout: addr = g*H*CW + y*CW + cw.
  task automatic build_model(input int c, input int h, input int w);
    int cw_n, g_n, addr, ncols;
    beat_t b;
    cw_n = (c >> 6) & 255;
    g_n  = (w + N - 1) / N;
    exp_q.delete();
    for (int g = 0; g < g_n; g++) begin
      for (int y = 0; y < h; y++) begin
        for (int cw = 0; cw < cw_n; cw++) begin
          addr = (g*h*cw_n + y*cw_n + cw) % 512;
          for (int i = 0; i < N; i++) b.data[i*DW +: DW] = bank_mem[i][addr];
          ncols   = (w - g*N < N) ? (w - g*N) : N;
          b.mask  = N'((1 << ncols) - 1);
          b.coord = {BC'(cw), BC'(y), BC'(g)};
          b.last  = (g == g_n-1) && (y == h-1) && (cw == cw_n-1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic run_pass(input int c, input int h, input int w, input int ready_mode,
                          input int wrx_mode, input int clr_at, input bit poke, input bit t1);
    int k, got, n_exp, first_valid, cw_n;
    bit stalled, want_done, finished;
    beat_t b;
    logic [349:0] held;
    logic [AW-1:0] a;
    build_model(c, h, w);
    n_exp = exp_q.size();
    cw_n = (c >> 6) & 255;
    got = 0; first_valid = -1; stalled = 0; want_done = 0; finished = 0;
    shape = {16'(w), 16'(h), 16'(c)};
    if (wrx_mode == 0) wr_x = BC'(w);
    else if (wrx_mode == 1) wr_x = BC'(5);
    else wr_x = BC'($urandom_range(0, w));
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (!finished && k < 3000) begin
      if (clr_at == k) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_valid", m_valid, 0);
        for (int j = 0; j < 5; j++) begin
          check("clr_no_done", done, 0);
          tick();
        end
        m_ready = 1'b0;
        return;
      end
      if (want_done) begin
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        finished = 1;
      end else begin
        check("done_early", done, 0);
        if (ready_mode == 0) m_ready = 1'b1;
        else if (ready_mode == 1) m_ready = (k % 2 == 1);
        else m_ready = ($urandom_range(0, 9) < 7);
        if (wrx_mode == 1 && k == 20) begin
          a = AW'(h * cw_n);
          check("hold_rdaddr", rdaddr, {N{a}});
          check("hold_beats", got, h * cw_n);
          wr_x = BC'(w);
        end
        if (wrx_mode == 2 && int'(wr_x) < w && $urandom_range(0, 3) == 0) wr_x = wr_x + 1'b1;
        if (poke && k == 2) begin
          start = 1'b1;
          shape = {16'd3, 16'd1, 16'd64};
        end else if (poke && k == 3) begin
          start = 1'b0;
        end
        if (t1 && k <= 4) begin
          a = AW'(k - 1);
          check("rdaddr_seq", rdaddr, {N{a}});
        end
        if (stalled) begin
          check("stall_valid", m_valid, 1);
          check("stall_hold", {m_data, m_mask, m_coord, m_last}, held);
        end
        if (m_valid && first_valid < 0) begin
          first_valid = k;
          if (t1) check("first_valid_latency", k, 3);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", m_data, b.data);
            check("beat_mask", m_mask, b.mask);
            check("beat_coord", m_coord, b.coord);
            check("beat_last", m_last, b.last);
            got++;
            if (b.last) want_done = 1;
          end
          stalled = 0;
        end else if (m_valid) begin
          stalled = 1;
          held = {m_data, m_mask, m_coord, m_last};
        end else begin
          stalled = 0;
        end
        tick();
        k++;
      end
    end
    if (!finished) check("pass_timeout", 0, 1);
    check("beat_count", got, n_exp);
    m_ready = 1'b0;
    start = 1'b0;
    tick();
    check("done_width", done, 0);
    check("stay_idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 512; j++)
        bank_mem[i][j] = {$urandom, $urandom};

    rstn = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_rdaddr", rdaddr, 0);
    rstn = 1'b1;
    tick();

    run_pass(128, 2, 5, 0, 0, -1, 0, 1);
    run_pass(64, 2, 7, 0, 0, -1, 0, 0);
    run_pass(128, 2, 5, 1, 0, -1, 0, 1);
    run_pass(64, 2, 7, 0, 1, -1, 0, 0);
    run_pass(128, 2, 5, 0, 0, 3, 0, 0);
    run_pass(128, 2, 5, 0, 0, -1, 0, 1);
    run_pass(128, 2, 5, 0, 0, -1, 1, 1);

    for (int z = 0; z < 3; z++) begin
      shape = (z == 0) ? {16'd5, 16'd2, 16'd32} : (z == 1) ? {16'd5, 16'd0, 16'd128}
                                                           : {16'd0, 16'd2, 16'd128};
      start = 1'b1;
      tick();
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_valid", m_valid, 0);
      for (int j = 0; j < 3; j++) begin
        tick();
        check("zero_no_valid", m_valid, 0);
        check("zero_done_low", done, 0);
      end
    end

    for (int r = 0; r < 12; r++) begin
      run_pass(64 * $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 12),
               2, 2, -1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
